// File: rtl/mask_unpack_pkg.sv
// Shared constants and state encoding for the masking-polynomial unpacker.
// Q, GAMMA1 and field widths for Dilithium levels 2 and 3/5.
package mask_unpack_pkg;

    localparam logic [23:0] Q            = 24'd8380417;
    localparam logic [23:0] GAMMA1_LVL2  = 24'd131072;
    localparam logic [23:0] GAMMA1_LVL35 = 24'd524288;

    localparam logic [7:0] W_LVL2  = 8'd18;
    localparam logic [7:0] W_LVL35 = 8'd20;

    localparam logic [6:0] NW_LVL2  = 7'd72;
    localparam logic [6:0] NW_LVL35 = 7'd80;

    localparam logic [7:0] BW_LVL2    = 8'd72;
    localparam logic [7:0] BW_LVL35   = 8'd80;
    localparam logic [7:0] READY_FILL = 8'd80;
    localparam logic [6:0] BEATS      = 7'd64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mask_coeff_map.sv
// Maps one W-bit SHAKE field z to the coefficient gamma1 - z mod q.
// Purely combinational; the top instantiates one per output lane.
module mask_coeff_map
    import mask_unpack_pkg::*;
(
    input  logic [19:0] z,
    input  logic        lvl2,
    output logic [23:0] lane
);

    logic [23:0] g1;
    logic [23:0] diff;

    // Unsigned wrap is fine: a negative diff plus Q lands back in [0, Q).
    always_comb begin
        g1   = lvl2 ? GAMMA1_LVL2 : GAMMA1_LVL35;
        diff = g1 - {4'b0, z};
        lane = diff[23] ? diff + Q : diff;
    end

endmodule

// File: rtl/mask_unpack.sv
// Streams 64-bit SHAKE words into 18/20-bit fields and emits four
// masking coefficients per beat, 64 beats per polynomial.
module mask_unpack
    import mask_unpack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sec_lvl,
    input  logic        start,
    input  logic        validi,
    input  logic [63:0] di,
    output logic        ready_o,
    output logic        valido,
    output logic [95:0] dout,
    input  logic        readyi,
    output logic        done
);

    state_t       state_q;
    state_t       state_d;
    logic         lvl2_q;
    logic [143:0] bits_q;
    logic [7:0]   fill;
    logic [6:0]   words_in;
    logic [6:0]   beats_out;

    logic [7:0]   bw;
    logic [6:0]   nw;
    logic         run;
    logic         acc;
    logic         hs;
    logic         load;
    logic [143:0] appended;
    logic [143:0] bits_d;
    logic [7:0]   fill_d;
    logic [95:0]  lanes;

    always_comb begin
        bw       = lvl2_q ? BW_LVL2 : BW_LVL35;
        nw       = lvl2_q ? NW_LVL2 : NW_LVL35;
        run      = (state_q == S_RUN);
        ready_o  = run && (fill <= READY_FILL) && (words_in < nw);
        acc      = validi && ready_o;
        hs       = valido && readyi;
        load     = run && (!valido || readyi) && (fill >= bw)
                   && (beats_out < BEATS);
        // Bits above fill are always zero, so OR-append is safe.
        appended = acc ? (bits_q | ({80'b0, di} << fill)) : bits_q;
        bits_d   = load ? (appended >> bw) : appended;
        fill_d   = fill + (acc ? 8'd64 : 8'd0) - (load ? bw : 8'd0);
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [19:0] z;
        assign z = lvl2_q ? {2'b0, bits_q[i*18 +: 18]}
                          : bits_q[i*20 +: 20];
        mask_coeff_map u_map (
            .z    (z),
            .lvl2 (lvl2_q),
            .lane (lanes[i*24 +: 24])
        );
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (hs && beats_out == BEATS - 7'd1) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lvl2_q    <= 1'b0;
            bits_q    <= '0;
            fill      <= '0;
            words_in  <= '0;
            beats_out <= '0;
            valido    <= 1'b0;
            dout      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                lvl2_q    <= (sec_lvl == 3'd2);
                bits_q    <= '0;
                fill      <= '0;
                words_in  <= '0;
                beats_out <= '0;
            end else begin
                bits_q <= bits_d;
                fill   <= fill_d;
                if (acc) words_in  <= words_in + 7'd1;
                if (hs)  beats_out <= beats_out + 7'd1;
            end
            if (load) begin
                valido <= 1'b1;
                dout   <= lanes;
            end else if (hs) begin
                valido <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mask_unpack.sv
// Directed bench for mask_unpack: constant patterns, counting and random
// streams against a bit-level slicing model, backpressure and abort.
module tb_mask_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sec_lvl;
    logic        start;
    logic        validi;
    logic [63:0] di;
    logic        ready_o;
    logic        valido;
    logic [95:0] dout;
    logic        readyi;
    logic        done;

    mask_unpack dut (
        .clk     (clk),
        .rst     (rst),
        .sec_lvl (sec_lvl),
        .start   (start),
        .validi  (validi),
        .di      (di),
        .ready_o (ready_o),
        .valido  (valido),
        .dout    (dout),
        .readyi  (readyi),
        .done    (done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] words [80];
    logic [95:0] beats [64];
    int nb, widx, done_cnt, stable_err, max_fill;
    bit timeout;

    function automatic logic [23:0] ref_lane(int k, int w, int g1);
        logic [19:0] z;
        int pos;
        int t;
        z = '0;
        for (int b = 0; b < w; b++) begin
            pos  = k * w + b;
            z[b] = words[pos / 64][pos % 64];
        end
        t = g1 - int'(z);
        if (t < 0) t = t + 8380417;
        return 24'(t);
    endfunction

    task automatic run_poly(input logic [2:0] lvl, input bit rnd,
                            input int abort_beat);
        logic [95:0] prev;
        bit held;
        int post;
        bit fin;
        nb = 0; widx = 0; done_cnt = 0; stable_err = 0;
        max_fill = 0; timeout = 0;
        held = 0; prev = '0; post = 0; fin = 0;
        for (int b = 0; b < 64; b++) beats[b] = '0;
        @(negedge clk);
        sec_lvl = lvl; start = 1'b1; validi = 1'b0; readyi = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) done_cnt++;
            if (held && dout !== prev) stable_err++;
            if (int'(dut.fill) > max_fill) max_fill = int'(dut.fill);
            if (abort_beat >= 0 && nb == abort_beat) begin
                rst = 1'b1; validi = 1'b0; readyi = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done_cnt > 0) post++;
            if (post > 8) begin
                fin = 1;
                break;
            end
            validi = rnd ? ($urandom_range(3) != 0) : 1'b1;
            di     = words[widx < 80 ? widx : 79];
            readyi = rnd ? 1'($urandom_range(1)) : 1'b1;
            #1;
            if (validi && ready_o) widx++;
            if (valido && readyi) begin
                if (nb < 64) beats[nb] = dout;
                nb++;
            end
            held = valido && !readyi;
            prev = dout;
            @(negedge clk);
        end
        validi = 1'b0; readyi = 1'b0;
        timeout = !fin;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; validi = 1'b0; readyi = 1'b0;
        sec_lvl = 3'd2; di = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready_o);
        else pass_cnt++;
        total_cnt++;
        if (valido !== 1'b0) $display("FAIL rst_valido: got %b want 0", valido);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 96'd0) $display("FAIL rst_dout: got %h want 0", dout);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done);
        else pass_cnt++;
        rst = 1'b0; validi = 1'b1; di = '1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (ready_o !== 1'b0 || valido !== 1'b0)
            $display("FAIL idle_ignore: ready %b valido %b want 0 0",
                     ready_o, valido);
        else pass_cnt++;
        validi = 1'b0;
    endtask

    task automatic test_const(input string nm, input logic [2:0] lvl,
                              input logic [63:0] w, input logic [23:0] exp,
                              input int exp_words);
        int bad;
        logic [23:0] got;
        for (int n = 0; n < 80; n++) words[n] = w;
        run_poly(lvl, 1'b0, -1);
        total_cnt++;
        if (timeout !== 1'b0) $display("FAIL %s_timeout: got 1 want 0", nm);
        else pass_cnt++;
        total_cnt++;
        if (nb != 64) $display("FAIL %s_beats: got %0d want 64", nm, nb);
        else pass_cnt++;
        total_cnt++;
        if (widx != exp_words)
            $display("FAIL %s_words: got %0d want %0d", nm, widx, exp_words);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1)
            $display("FAIL %s_done: got %0d want 1", nm, done_cnt);
        else pass_cnt++;
        bad = 0; got = '0;
        for (int b = 0; b < 64; b++)
            for (int i = 0; i < 4; i++)
                if (beats[b][i*24 +: 24] !== exp) begin
                    if (bad == 0) got = beats[b][i*24 +: 24];
                    bad++;
                end
        total_cnt++;
        if (bad != 0)
            $display("FAIL %s_lanes: %0d bad, first got %0d want %0d",
                     nm, bad, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_lvl5_count;
        int bad;
        for (int n = 0; n < 80; n++) words[n] = 64'(n);
        run_poly(3'd5, 1'b0, -1);
        total_cnt++;
        if (nb != 64 || timeout) $display("FAIL l5_beats: got %0d want 64", nb);
        else pass_cnt++;
        total_cnt++;
        if (widx != 80) $display("FAIL l5_words: got %0d want 80", widx);
        else pass_cnt++;
        bad = 0;
        for (int b = 0; b < 64; b++)
            for (int i = 0; i < 4; i++)
                if (beats[b][i*24 +: 24] !== ref_lane(4*b + i, 20, 524288))
                    bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL l5_lanes: got %0d bad want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int bad;
        for (int n = 0; n < 80; n++) words[n] = {$urandom, $urandom};
        run_poly(3'd2, 1'b1, -1);
        total_cnt++;
        if (timeout !== 1'b0) $display("FAIL bp_timeout: got 1 want 0");
        else pass_cnt++;
        total_cnt++;
        if (nb != 64) $display("FAIL bp_beats: got %0d want 64", nb);
        else pass_cnt++;
        total_cnt++;
        if (widx != 72) $display("FAIL bp_words: got %0d want 72", widx);
        else pass_cnt++;
        total_cnt++;
        if (stable_err != 0)
            $display("FAIL bp_stable: got %0d changes want 0", stable_err);
        else pass_cnt++;
        total_cnt++;
        if (max_fill > 144) $display("FAIL bp_fill: got %0d want <=144", max_fill);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt);
        else pass_cnt++;
        bad = 0;
        for (int b = 0; b < 64; b++)
            for (int i = 0; i < 4; i++)
                if (beats[b][i*24 +: 24] !== ref_lane(4*b + i, 18, 131072))
                    bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL bp_lanes: got %0d bad want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        for (int n = 0; n < 80; n++) words[n] = '1;
        run_poly(3'd2, 1'b0, 30);
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL ab_ready: got %b want 0", ready_o);
        else pass_cnt++;
        total_cnt++;
        if (valido !== 1'b0) $display("FAIL ab_valido: got %b want 0", valido);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 96'd0) $display("FAIL ab_dout: got %h want 0", dout);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL ab_done: got %b want 0", done);
        else pass_cnt++;
        test_const("ab_fresh", 3'd2, 64'd0, 24'd131072, 72);
    endtask

    initial begin
        test_reset;
        test_const("l2z", 3'd2, 64'd0, 24'd131072, 72);
        test_const("l2o", 3'd2, '1, 24'd8249346, 72);
        test_const("l3o", 3'd3, '1, 24'd7856130, 80);
        test_const("l3z", 3'd3, 64'd0, 24'd524288, 80);
        test_lvl5_count;
        test_backpressure;
        test_abort;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
